// File: rtl/led_pkg.sv
// Shared constants for the LED PWM driver: config addresses, reset values
// and the blink FSM state encoding (the codes are visible through STATUS).
package led_pkg;

    localparam logic [1:0] ADDR_DUTY   = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_MODE   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int MODE_BLINK_BIT = 0;

    localparam logic [7:0] DUTY_RST   = 8'hFF;
    localparam logic [7:0] PERIOD_RST = 8'h00;

    typedef enum logic [1:0] {
        ST_SOLID     = 2'd0,
        ST_BLINK_ON  = 2'd1,
        ST_BLINK_OFF = 2'd2
    } blink_state_t;

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler: counts 0..PRESCALE-1 and raises o_tick for the
// single cycle in which the count sits at its last value.
module led_tick_gen #(
    parameter int PRESCALE = 1000
) (
    input  logic i_clk,
    input  logic i_nreset,
    output logic o_tick
);

    localparam int             CW   = $clog2(PRESCALE);
    localparam logic [CW-1:0]  LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_cnt;

    // Prescale counter, wraps to zero after the tick cycle.
    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/led_pwm_driver.sv
// Drives the board LED pins from the LED register pattern, adding global
// PWM dimming, optional blinking and pin polarity. Small config port with
// DUTY / PERIOD / MODE / STATUS registers.
// Config handshake: cfg_wr_en and cfg_rd_en are single-cycle strobes with
// no back-pressure; a write lands on the strobe edge, a read captures the
// pre-edge value of the addressed register into cfg_data_out on the strobe
// edge and cfg_data_out holds until the next read.
module led_pwm_driver
    import led_pkg::*;
#(
    parameter int PRESCALE   = 1000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic [7:0] led_in,
    input  logic       cfg_wr_en,
    input  logic       cfg_rd_en,
    input  logic [1:0] cfg_addr,
    input  logic [7:0] cfg_data_in,
    output logic [7:0] cfg_data_out,
    output logic [7:0] led_out
);

    localparam logic [7:0] LED_DARK = ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [7:0]   r_duty;
    logic [7:0]   r_period;
    logic         r_mode_blink;
    logic [7:0]   r_pwm_cnt;
    logic [7:0]   r_blink_cnt;
    blink_state_t r_state;
    logic [7:0]   r_cfg_data_out;
    logic [7:0]   r_led_out;

    logic         w_tick;
    logic         w_wr_period;
    logic         w_pwm_on;
    logic         w_phase_on;
    logic [7:0]   w_lit;
    logic [7:0]   w_rd_val;

    led_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .i_clk    (clk),
        .i_nreset (nreset),
        .o_tick   (w_tick)
    );

    assign w_wr_period = cfg_wr_en && (cfg_addr == ADDR_PERIOD);

    // Config register writes; STATUS is read-only so addr3 writes fall through.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_duty       <= DUTY_RST;
            r_period     <= PERIOD_RST;
            r_mode_blink <= 1'b0;
        end else if (cfg_wr_en) begin
            case (cfg_addr)
                ADDR_DUTY:   r_duty       <= cfg_data_in;
                ADDR_PERIOD: r_period     <= cfg_data_in;
                ADDR_MODE:   r_mode_blink <= cfg_data_in[MODE_BLINK_BIT];
                default:     ;
            endcase
        end
    end

    // Read mux over current (pre-write) register contents.
    always_comb begin
        w_rd_val = 8'h00;
        case (cfg_addr)
            ADDR_DUTY:   w_rd_val = r_duty;
            ADDR_PERIOD: w_rd_val = r_period;
            ADDR_MODE:   w_rd_val = {7'b0, r_mode_blink};
            ADDR_STATUS: w_rd_val = {6'b0, r_state};
            default:     w_rd_val = 8'h00;
        endcase
    end

    // Registered read data, held between read strobes.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_cfg_data_out <= 8'h00;
        end else if (cfg_rd_en) begin
            r_cfg_data_out <= w_rd_val;
        end
    end

    // Free-running PWM ramp, wraps 255 -> 0.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_pwm_cnt <= 8'h00;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end
    end

    // Blink FSM: leaving blink mode wins, then entry, then PERIOD rewrite,
    // then tick-driven counting. PERIOD=0 never matches so the phase freezes.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state     <= ST_SOLID;
            r_blink_cnt <= 8'h00;
        end else if (!r_mode_blink) begin
            r_state     <= ST_SOLID;
            r_blink_cnt <= 8'h00;
        end else begin
            case (r_state)
                ST_SOLID: begin
                    r_state     <= ST_BLINK_ON;
                    r_blink_cnt <= 8'h00;
                end
                ST_BLINK_ON, ST_BLINK_OFF: begin
                    if (w_wr_period) begin
                        r_blink_cnt <= 8'h00;
                    end else if (w_tick) begin
                        if ((r_period != 8'h00) && (r_blink_cnt == r_period - 8'd1)) begin
                            r_state     <= (r_state == ST_BLINK_ON) ? ST_BLINK_OFF : ST_BLINK_ON;
                            r_blink_cnt <= 8'h00;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_SOLID;
                    r_blink_cnt <= 8'h00;
                end
            endcase
        end
    end

    assign w_pwm_on   = (r_duty == 8'hFF) || (r_pwm_cnt < r_duty);
    assign w_phase_on = (r_state != ST_BLINK_OFF);
    assign w_lit      = led_in & {8{w_pwm_on & w_phase_on}};

    // Output pins with polarity applied; reset forces them dark immediately.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_led_out <= LED_DARK;
        end else begin
            r_led_out <= ACTIVE_LOW ? ~w_lit : w_lit;
        end
    end

    assign led_out      = r_led_out;
    assign cfg_data_out = r_cfg_data_out;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Bench for led_pwm_driver (PRESCALE=4, active-low pins). A cycle-level
// reference built from the documented rules (cycle index arithmetic for the
// PWM ramp and tick, phase/period bookkeeping for blinking) predicts
// led_out and cfg_data_out after every clock; directed steps add fixed
// expectations from the test plan, then a randomized phase runs.
module tb_led_pwm_driver;

    localparam int P       = 4;
    localparam bit ACT_LOW = 1'b1;

    logic       clk = 1'b0;
    logic       nreset;
    logic [7:0] led_in;
    logic       cfg_wr_en;
    logic       cfg_rd_en;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_data_in;
    logic [7:0] cfg_data_out;
    logic [7:0] led_out;

    int n_checks = 0;
    int n_errors = 0;

    // reference model
    int         m_cyc;
    logic [7:0] m_duty, m_period, m_bcnt, m_led, m_rd;
    logic       m_mode;
    int         m_st;

    led_pwm_driver #(
        .PRESCALE   (P),
        .ACTIVE_LOW (ACT_LOW)
    ) dut (
        .clk          (clk),
        .nreset       (nreset),
        .led_in       (led_in),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_rd_en    (cfg_rd_en),
        .cfg_addr     (cfg_addr),
        .cfg_data_in  (cfg_data_in),
        .cfg_data_out (cfg_data_out),
        .led_out      (led_out)
    );

    always #5 clk = ~clk;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp) else begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic model_reset();
        m_cyc    = 0;
        m_duty   = 8'hFF;
        m_period = 8'h00;
        m_mode   = 1'b0;
        m_st     = 0;
        m_bcnt   = 8'h00;
        m_led    = ACT_LOW ? 8'hFF : 8'h00;
        m_rd     = 8'h00;
    endtask

    // One clock: predict from pre-edge state and inputs, clock, then compare.
    task automatic cycle();
        logic [7:0] pwm, lit, rdv, n_led, n_rd, n_bcnt;
        logic [7:0] n_duty, n_period;
        logic       n_mode;
        int         n_st;
        bit         tick, on;
        pwm  = 8'(m_cyc % 256);
        tick = ((m_cyc % P) == P - 1);
        on   = (m_duty == 8'hFF) || (pwm < m_duty);
        lit  = (on && m_st != 2) ? led_in : 8'h00;
        n_led = ACT_LOW ? ~lit : lit;
        case (cfg_addr)
            2'd0:    rdv = m_duty;
            2'd1:    rdv = m_period;
            2'd2:    rdv = {7'b0, m_mode};
            default: rdv = 8'(m_st);
        endcase
        n_rd = cfg_rd_en ? rdv : m_rd;
        n_st = m_st;
        n_bcnt = m_bcnt;
        if (!m_mode) begin
            n_st = 0; n_bcnt = 0;
        end else if (m_st == 0) begin
            n_st = 1; n_bcnt = 0;
        end else if (cfg_wr_en && cfg_addr == 2'd1) begin
            n_bcnt = 0;
        end else if (tick) begin
            if (m_period != 0 && int'(m_bcnt) == int'(m_period) - 1) begin
                n_st = (m_st == 1) ? 2 : 1;
                n_bcnt = 0;
            end else begin
                n_bcnt = m_bcnt + 8'd1;
            end
        end
        n_duty = m_duty; n_period = m_period; n_mode = m_mode;
        if (cfg_wr_en) begin
            if (cfg_addr == 2'd0) n_duty = cfg_data_in;
            if (cfg_addr == 2'd1) n_period = cfg_data_in;
            if (cfg_addr == 2'd2) n_mode = cfg_data_in[0];
        end
        @(posedge clk);
        #1;
        m_led = n_led; m_rd = n_rd; m_st = n_st; m_bcnt = n_bcnt;
        m_duty = n_duty; m_period = n_period; m_mode = n_mode;
        m_cyc++;
        cfg_wr_en = 1'b0;
        cfg_rd_en = 1'b0;
        chk8("led_out", led_out, m_led);
        chk8("cfg_data_out", cfg_data_out, m_rd);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [7:0] d);
        cfg_wr_en = 1'b1; cfg_addr = a; cfg_data_in = d;
        cycle();
    endtask

    task automatic cfg_rd(input logic [1:0] a);
        cfg_rd_en = 1'b1; cfg_addr = a;
        cycle();
    endtask

    // Mid-cycle asynchronous reset; pins must go dark before any edge.
    task automatic apply_reset();
        #2 nreset = 1'b0;
        #1;
        chk8("async_dark", led_out, 8'hFF);
        chk8("rst_cfg_data_out", cfg_data_out, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        nreset = 1'b1;
    endtask

    // Clocks until led_out differs from its current value (bounded).
    task automatic wait_change(output int n);
        logic [7:0] v;
        v = led_out;
        n = 0;
        while (n < 200) begin
            cycle();
            n++;
            if (led_out !== v) break;
        end
        if (led_out === v) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_change: led_out stuck at %h for %0d clks", v, n);
        end
    endtask

    int cnt, nchg;
    logic [7:0] prev;

    initial begin
        nreset      = 1'b0;
        led_in      = 8'h00;
        cfg_wr_en   = 1'b0;
        cfg_rd_en   = 1'b0;
        cfg_addr    = 2'd0;
        cfg_data_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk8("power_on_dark", led_out, 8'hFF);
        model_reset();
        nreset = 1'b1;

        // 1: reset mid-run, then first clock at full brightness
        led_in = 8'h3C;
        run(20);
        apply_reset();
        cycle();
        chk8("first_clk_after_rst", led_out, 8'hC3);
        cfg_rd(2'd3);
        chk8("status_after_rst", cfg_data_out, 8'h00);

        // 2: passthrough at default duty
        led_in = 8'hA5;
        cycle();
        chk8("pass_latency", led_out, 8'h5A);
        cnt = 0;
        for (int i = 0; i < 512; i++) begin
            cycle();
            if (led_out === 8'h5A) cnt++;
        end
        chk_int("pass_constant_512", cnt, 512);

        // 3: PWM duty 0x40 -> lit 64 of 256; duty 0 -> never lit
        cfg_wr(2'd0, 8'h40);
        led_in = 8'h01;
        cycle();
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            cycle();
            if (led_out[0] === 1'b0) cnt++;
        end
        chk_int("duty40_lit_clks", cnt, 64);
        cfg_wr(2'd0, 8'h00);
        cycle();
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (led_out[0] === 1'b1) cnt++;
        end
        chk_int("duty0_dark_clks", cnt, 300);
        cfg_wr(2'd0, 8'hFF);

        // 4: blinking with PERIOD=3 -> 12 clk phases
        led_in = 8'hFF;
        cfg_wr(2'd1, 8'd3);
        cfg_wr(2'd2, 8'h01);
        cycle();
        cfg_rd(2'd3);
        chk8("status_blink_on", cfg_data_out, 8'h01);
        wait_change(cnt);
        wait_change(cnt);
        chk_int("blink_half_period_a", cnt, 12);
        wait_change(cnt);
        chk_int("blink_half_period_b", cnt, 12);

        // 6: rewrite PERIOD in BLINK_OFF with blink_cnt=2
        for (int i = 0; i < 4 && led_out !== 8'hFF; i++) wait_change(cnt);
        chk8("in_blink_off", led_out, 8'hFF);
        run(7);
        cfg_wr(2'd1, 8'd5);
        wait_change(cnt);
        chk_int("period_rewrite_gap", cnt, 5 * P);

        // 4 cont.: PERIOD=0 freezes the phase
        cfg_wr(2'd1, 8'd0);
        cycle();
        nchg = 0;
        prev = led_out;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (led_out !== prev) nchg++;
            prev = led_out;
        end
        chk_int("period0_frozen", nchg, 0);

        // 4 cont.: clearing MODE returns to SOLID
        cfg_wr(2'd2, 8'h00);
        cycle();
        chk8("solid_led_on", led_out, 8'h00);
        cfg_rd(2'd3);
        chk8("status_solid", cfg_data_out, 8'h00);

        // 5: config read/write behaviour
        cfg_wr(2'd2, 8'hFF);
        cfg_rd(2'd2);
        chk8("mode_readback", cfg_data_out, 8'h01);
        cfg_wr(2'd2, 8'h00);
        cycle();
        cfg_wr_en = 1'b1; cfg_rd_en = 1'b1; cfg_addr = 2'd0; cfg_data_in = 8'h10;
        cycle();
        chk8("rw_same_cycle_old", cfg_data_out, 8'hFF);
        cfg_rd(2'd0);
        chk8("rw_then_new", cfg_data_out, 8'h10);
        cfg_wr(2'd3, 8'hAA);
        cfg_rd(2'd3);
        chk8("status_write_ignored", cfg_data_out, 8'h00);
        cycle();
        chk8("hold_rd_data", cfg_data_out, 8'h00);
        cfg_wr(2'd0, 8'hFF);

        // randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            led_in = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                cfg_wr_en = 1'b1;
                cfg_addr  = 2'($urandom_range(0, 3));
                cfg_data_in = (cfg_addr == 2'd1) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            end
            if ($urandom_range(0, 2) == 0) begin
                cfg_rd_en = 1'b1;
                if (!cfg_wr_en) cfg_addr = 2'($urandom_range(0, 3));
            end
            if (i == 1200) apply_reset();
            else cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
